// File: rtl/vx_tcu_fedp_seq_pkg.sv
// rtl/vx_tcu_fedp_seq_pkg.sv - shared tcu constants and sequencer state encoding
package vx_tcu_fedp_seq_pkg;

    localparam int XLEN = 32;

    // Source-format encodings understood by the attached FEDP.
    localparam logic [2:0] FMT_FP16 = 3'd1;
    localparam logic [2:0] FMT_BF16 = 3'd2;
    localparam logic [2:0] FMT_TF32 = 3'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/vx_tcu_fedp_seq.sv
// rtl/vx_tcu_fedp_seq.sv - multi-step dot-product sequencer around a fixed-latency FEDP
module vx_tcu_fedp_seq
    import vx_tcu_fedp_seq_pkg::*;
#(
    parameter int N         = 4,
    parameter int LATENCY   = 16,
    parameter int MAX_STEPS = 16,
    localparam int SW       = $clog2(MAX_STEPS + 1)
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_fmt_s,
    input  logic [2:0]        req_fmt_d,
    input  logic [SW-1:0]     req_steps,
    input  logic [XLEN-1:0]   req_c,

    input  logic              opd_valid,
    output logic              opd_ready,
    input  logic [N*XLEN-1:0] opd_a,
    input  logic [N*XLEN-1:0] opd_b,

    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [XLEN-1:0]   rsp_data,

    output logic              fedp_enable,
    output logic [2:0]        fedp_fmt_s,
    output logic [2:0]        fedp_fmt_d,
    output logic [N*XLEN-1:0] fedp_a_row,
    output logic [N*XLEN-1:0] fedp_b_col,
    output logic [XLEN-1:0]   fedp_c_val,
    input  logic [XLEN-1:0]   fedp_d_val,

    output logic              busy
);

    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [SW-1:0] MAX_STEPS_W = SW'(MAX_STEPS);
    localparam logic [CW-1:0] CNT_LOAD    = CW'(LATENCY - 1);

    state_t          state;
    state_t          state_nxt;
    logic [2:0]      fmt_s_r;
    logic [2:0]      fmt_d_r;
    logic [SW-1:0]   steps_r;
    logic [SW-1:0]   step_cnt;
    logic [CW-1:0]   cnt;
    logic [XLEN-1:0] acc;

    logic            req_fire;
    logic            opd_fire;
    logic            capture;
    logic            last_step;
    logic [SW-1:0]   steps_clamped;

    assign req_fire      = req_valid && req_ready;
    assign opd_fire      = opd_valid && opd_ready;
    // The FEDP result is only trusted on the cycle our own counter expires;
    // anything still draining from before a reset never lines up with it.
    assign capture       = (state == ST_WAIT) && (cnt == '0);
    assign last_step     = (step_cnt + SW'(1)) == steps_r;
    assign steps_clamped = (req_steps > MAX_STEPS_W) ? MAX_STEPS_W : req_steps;

    // The FEDP free-runs; operands and accumulator are simply passed through
    // and only matter in the issue cycle.
    assign fedp_enable = 1'b1;
    assign fedp_fmt_s  = fmt_s_r;
    assign fedp_fmt_d  = fmt_d_r;
    assign fedp_a_row  = opd_a;
    assign fedp_b_col  = opd_b;
    assign fedp_c_val  = acc;

    assign rsp_data = acc;
    assign busy     = (state != ST_IDLE);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        opd_ready = 1'b0;
        rsp_valid = 1'b0;
        case (state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_nxt = (steps_clamped == '0) ? ST_DONE : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                opd_ready = 1'b1;
                if (opd_valid) begin
                    state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (capture) begin
                    state_nxt = last_step ? ST_DONE : ST_ISSUE;
                end
            end
            ST_DONE: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Request latch, latency counter, step counter and accumulator.
    always_ff @(posedge clk) begin
        if (reset) begin
            fmt_s_r  <= '0;
            fmt_d_r  <= '0;
            steps_r  <= '0;
            step_cnt <= '0;
            cnt      <= '0;
            acc      <= '0;
        end else begin
            if (req_fire) begin
                fmt_s_r  <= req_fmt_s;
                fmt_d_r  <= req_fmt_d;
                steps_r  <= steps_clamped;
                step_cnt <= '0;
                acc      <= req_c;
            end
            if (opd_fire) begin
                cnt <= CNT_LOAD;
            end else if (state == ST_WAIT && cnt != '0) begin
                cnt <= cnt - CW'(1);
            end
            if (capture) begin
                acc      <= fedp_d_val;
                step_cnt <= step_cnt + SW'(1);
            end
        end
    end

endmodule

// File: tb/tb_vx_tcu_fedp_seq.sv
// tb/tb_vx_tcu_fedp_seq.sv - directed self-checking bench for vx_tcu_fedp_seq
module tb_vx_tcu_fedp_seq;

    localparam int N    = 4;
    localparam int LAT  = 16;
    localparam int MAXS = 16;
    localparam int SW   = $clog2(MAXS + 1);

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic [2:0]        req_fmt_s = '0;
    logic [2:0]        req_fmt_d = '0;
    logic [SW-1:0]     req_steps = '0;
    logic [31:0]       req_c = '0;
    logic              opd_valid = 1'b1;
    logic              opd_ready;
    logic [N*32-1:0]   opd_a = '0;
    logic [N*32-1:0]   opd_b = '0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b1;
    logic [31:0]       rsp_data;
    logic              fedp_enable;
    logic [2:0]        fedp_fmt_s;
    logic [2:0]        fedp_fmt_d;
    logic [N*32-1:0]   fedp_a_row;
    logic [N*32-1:0]   fedp_b_col;
    logic [31:0]       fedp_c_val;
    logic [31:0]       fedp_d_val;
    logic              busy;

    int passed = 0;
    int total  = 0;
    int cyc    = 0;
    int overlap = 0;
    int issues[$];
    logic [31:0] issue_c[$];

    vx_tcu_fedp_seq #(.N(N), .LATENCY(LAT), .MAX_STEPS(MAXS)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_fmt_s(req_fmt_s), .req_fmt_d(req_fmt_d),
        .req_steps(req_steps), .req_c(req_c),
        .opd_valid(opd_valid), .opd_ready(opd_ready),
        .opd_a(opd_a), .opd_b(opd_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .fedp_enable(fedp_enable), .fedp_fmt_s(fedp_fmt_s), .fedp_fmt_d(fedp_fmt_d),
        .fedp_a_row(fedp_a_row), .fedp_b_col(fedp_b_col),
        .fedp_c_val(fedp_c_val), .fedp_d_val(fedp_d_val),
        .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Observe issues and the ready-exclusivity rule mid-cycle.
    always @(negedge clk) begin
        if (opd_valid && opd_ready) begin
            issues.push_back(cyc);
            issue_c.push_back(fedp_c_val);
        end
        if (req_ready && opd_ready) overlap = overlap + 1;
    end

    // Behavioural FEDP: c + a.b computed when sampled, delivered LAT cycles later.
    function automatic real half_to_real(input logic [2:0] fmt, input logic [15:0] h);
        int  e;
        real f;
        real v;
        if (fmt == 3'd2) begin
            e = int'(h[14:7]);
            f = real'(int'(h[6:0]));
            v = (e == 0) ? 0.0 : (1.0 + f / 128.0) * (2.0 ** (e - 127));
        end else begin
            e = int'(h[14:10]);
            f = real'(int'(h[9:0]));
            v = (e == 0) ? f * (2.0 ** (-24)) : (1.0 + f / 1024.0) * (2.0 ** (e - 15));
        end
        return h[15] ? -v : v;
    endfunction

    function automatic real fp32_to_real(input logic [31:0] w);
        int  e;
        real v;
        e = int'(w[30:23]);
        v = (e == 0) ? 0.0 : (1.0 + real'(int'(w[22:0])) / 8388608.0) * (2.0 ** (e - 127));
        return w[31] ? -v : v;
    endfunction

    function automatic logic [31:0] real_to_fp32(input real r);
        logic [63:0] b;
        int          ee;
        if (r == 0.0) return 32'h0;
        b  = $realtobits(r);
        ee = int'(b[62:52]) - 896;
        return {b[63], ee[7:0], b[51:29]};
    endfunction

    function automatic logic [31:0] fedp_model(input logic [2:0] fmt, input logic [N*32-1:0] a,
                                               input logic [N*32-1:0] b, input logic [31:0] c);
        real s;
        logic [31:0] aw;
        logic [31:0] bw;
        s = fp32_to_real(c);
        for (int w = 0; w < N; w++) begin
            aw = a[w*32 +: 32];
            bw = b[w*32 +: 32];
            if (fmt == 3'd3) begin
                s = s + fp32_to_real(aw & 32'hFFFFE000) * fp32_to_real(bw & 32'hFFFFE000);
            end else begin
                s = s + half_to_real(fmt, aw[15:0]) * half_to_real(fmt, bw[15:0]);
                s = s + half_to_real(fmt, aw[31:16]) * half_to_real(fmt, bw[31:16]);
            end
        end
        return real_to_fp32(s);
    endfunction

    logic [31:0] pipe [0:LAT-1];
    always @(posedge clk) begin
        pipe[0] <= fedp_model(fedp_fmt_s, fedp_a_row, fedp_b_col, fedp_c_val);
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign fedp_d_val = pipe[LAT-1];

    task automatic send_req(input logic [2:0] fs, input logic [2:0] fd, input logic [SW-1:0] st,
                            input logic [31:0] c, output int acc_cyc);
        bit got;
        got = 0;
        @(posedge clk); #1;
        req_valid = 1'b1; req_fmt_s = fs; req_fmt_d = fd; req_steps = st; req_c = c;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (req_ready) got = 1;
        end
        acc_cyc = cyc;
        total++;
        if (!got) $display("FAIL req_accept: req_ready=%0b required 1 within 50 cycles", req_ready);
        else passed++;
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(input string name, output int rc);
        bit got;
        got = 0;
        rc = -1;
        for (int i = 0; i < 400 && !got; i++) begin
            @(negedge clk);
            if (rsp_valid) begin got = 1; rc = cyc; end
        end
        total++;
        if (!got) $display("FAIL %s_rsp_timeout: rsp_valid=0 required 1 within 400 cycles", name);
        else passed++;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        total++; if (req_ready !== 1'b1) $display("FAIL reset_req_ready: got %0b want 1", req_ready); else passed++;
        total++; if (opd_ready !== 1'b0) $display("FAIL reset_opd_ready: got %0b want 0", opd_ready); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %0b want 0", busy); else passed++;
        total++; if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid: got %0b want 0", rsp_valid); else passed++;
        total++; if (rsp_data !== 32'h0) $display("FAIL reset_rsp_data: got %h want 0", rsp_data); else passed++;
        total++; if (fedp_enable !== 1'b1) $display("FAIL reset_fedp_enable: got %0b want 1", fedp_enable); else passed++;
    endtask

    task automatic test_fp16_three_steps();
        int a;
        int rc;
        opd_a = {N{32'h3C003C00}}; opd_b = {N{32'h3C003C00}}; opd_valid = 1'b1;
        issues.delete(); issue_c.delete();
        send_req(3'd1, 3'd0, SW'(3), 32'h0, a);
        wait_rsp("fp16", rc);
        total++; if (rc - a !== 52) $display("FAIL fp16_rsp_cycle: got %0d want 52", rc - a); else passed++;
        total++; if (rsp_data !== 32'h41C00000) $display("FAIL fp16_rsp_data: got %h want 41c00000", rsp_data); else passed++;
        total++; if (busy !== 1'b1) $display("FAIL fp16_busy_done: got %0b want 1", busy); else passed++;
        total++; if (fedp_fmt_s !== 3'd1) $display("FAIL fp16_fmt_s: got %0d want 1", fedp_fmt_s); else passed++;
        total++;
        if (issues.size() != 3) $display("FAIL fp16_issue_count: got %0d want 3", issues.size());
        else if (issues[0] - a != 1 || issues[1] - a != 18 || issues[2] - a != 35)
            $display("FAIL fp16_issue_cycles: got %0d,%0d,%0d want 1,18,35", issues[0]-a, issues[1]-a, issues[2]-a);
        else passed++;
        total++;
        if (issue_c.size() < 2 || issue_c[1] !== 32'h41000000)
            $display("FAIL fp16_issue_c: got %h want 41000000", (issue_c.size() < 2) ? 32'hx : issue_c[1]);
        else passed++;
        @(negedge clk);
        total++; if (req_ready !== 1'b1 || busy !== 1'b0) $display("FAIL fp16_back_idle: req_ready=%0b busy=%0b want 1,0", req_ready, busy); else passed++;
    endtask

    task automatic test_bf16_one_step();
        int a;
        int rc;
        opd_a = {N{32'h3F803F80}}; opd_b = {N{32'h40004000}};
        send_req(3'd2, 3'd0, SW'(1), 32'h3F800000, a);
        wait_rsp("bf16", rc);
        total++; if (rc - a !== 18) $display("FAIL bf16_rsp_cycle: got %0d want 18", rc - a); else passed++;
        total++; if (rsp_data !== 32'h41880000) $display("FAIL bf16_rsp_data: got %h want 41880000", rsp_data); else passed++;
    endtask

    task automatic test_zero_steps();
        int a;
        int rc;
        issues.delete(); issue_c.delete();
        send_req(3'd1, 3'd0, SW'(0), 32'h40490FDB, a);
        wait_rsp("zero", rc);
        total++; if (rc - a !== 1) $display("FAIL zero_rsp_cycle: got %0d want 1", rc - a); else passed++;
        total++; if (rsp_data !== 32'h40490FDB) $display("FAIL zero_rsp_data: got %h want 40490fdb", rsp_data); else passed++;
        total++; if (issues.size() != 0) $display("FAIL zero_no_issue: got %0d issues want 0", issues.size()); else passed++;
    endtask

    task automatic test_backpressure();
        int a;
        int rc;
        int bad;
        bad = 0;
        @(posedge clk); #1 rsp_ready = 1'b0;
        send_req(3'd1, 3'd0, SW'(0), 32'h12345678, a);
        wait_rsp("bp", rc);
        for (int i = 0; i < 10; i++) begin
            if (i > 0) @(negedge clk);
            if (!rsp_valid || rsp_data !== 32'h12345678 || req_ready) bad++;
        end
        total++; if (bad != 0) $display("FAIL bp_hold: %0d unstable cycles want 0", bad); else passed++;
        @(posedge clk); #1 rsp_ready = 1'b1;
        @(negedge clk);
        total++; if (rsp_valid !== 1'b1) $display("FAIL bp_release_valid: got %0b want 1", rsp_valid); else passed++;
        @(negedge clk);
        total++; if (req_ready !== 1'b1 || busy !== 1'b0) $display("FAIL bp_idle: req_ready=%0b busy=%0b want 1,0", req_ready, busy); else passed++;
    endtask

    task automatic test_opd_stall();
        int a;
        int rc;
        opd_a = {N{32'h3C003C00}}; opd_b = {N{32'h3C003C00}}; opd_valid = 1'b1;
        issues.delete(); issue_c.delete();
        send_req(3'd1, 3'd0, SW'(3), 32'h0, a);
        for (int i = 0; i < 60 && cyc < a + 23; i++) begin
            @(posedge clk); #1;
            if (cyc == a + 18) opd_valid = 1'b0;
            if (cyc == a + 23) opd_valid = 1'b1;
        end
        opd_valid = 1'b1;
        wait_rsp("stall", rc);
        total++; if (rc - a !== 57) $display("FAIL stall_rsp_cycle: got %0d want 57", rc - a); else passed++;
        total++; if (rsp_data !== 32'h41C00000) $display("FAIL stall_rsp_data: got %h want 41c00000", rsp_data); else passed++;
        total++;
        if (issues.size() != 3 || issues[1] - a != 23)
            $display("FAIL stall_issue1: got %0d want 23", (issues.size() > 1) ? issues[1] - a : -1);
        else passed++;
    endtask

    task automatic test_clamp();
        int a;
        int rc;
        opd_a = {N{32'h3C003C00}}; opd_b = {N{32'h3C003C00}};
        issues.delete(); issue_c.delete();
        send_req(3'd1, 3'd0, SW'(20), 32'h0, a);
        wait_rsp("clamp", rc);
        total++; if (rc - a !== 273) $display("FAIL clamp_rsp_cycle: got %0d want 273", rc - a); else passed++;
        total++; if (rsp_data !== 32'h43000000) $display("FAIL clamp_rsp_data: got %h want 43000000", rsp_data); else passed++;
        total++; if (issues.size() != 16) $display("FAIL clamp_issue_count: got %0d want 16", issues.size()); else passed++;
    endtask

    task automatic test_reset_mid();
        int a;
        int rc;
        opd_a = {N{32'h40004000}}; opd_b = {N{32'h40004000}};
        send_req(3'd1, 3'd0, SW'(1), 32'h0, a);
        for (int i = 0; i < 20 && cyc < a + 8; i++) begin
            @(posedge clk); #1;
        end
        reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        total++; if (busy !== 1'b0 || req_ready !== 1'b1) $display("FAIL rst_mid_idle: busy=%0b req_ready=%0b want 0,1", busy, req_ready); else passed++;
        opd_a = {N{32'h3C003C00}}; opd_b = {N{32'h3C003C00}};
        send_req(3'd1, 3'd0, SW'(1), 32'h0, a);
        wait_rsp("rst_mid", rc);
        total++; if (rc - a !== 18) $display("FAIL rst_mid_rsp_cycle: got %0d want 18", rc - a); else passed++;
        total++; if (rsp_data !== 32'h41000000) $display("FAIL rst_mid_rsp_data: got %h want 41000000", rsp_data); else passed++;
    endtask

    initial begin
        test_reset();
        test_fp16_three_steps();
        test_bf16_one_step();
        test_zero_steps();
        test_backpressure();
        test_opd_stall();
        test_clamp();
        test_reset_mid();
        repeat (2) @(negedge clk);
        total++; if (overlap != 0) $display("FAIL ready_exclusive: %0d overlap cycles want 0", overlap); else passed++;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
